// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Main control FSM for a multicycle RV32I datapath. Moore machine: every
//   output is a function of the current state (plus the opcode where the
//   immediate format has to be chosen). The one exception is PCWrite in
//   BRANCH, which follows the ALU flags in that same cycle.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset -> FETCH
//   opcode     in   IR[6:0]
//   func3      in   IR[14:12]
//   zero       in   ALU result == 0
//   neg        in   ALU signed-less-than flag
//   PCWrite    out  PC load enable
//   AdrSrc     out  memory address select (0=PC, 1=ALUOut)
//   MemWrite   out  data memory write enable
//   IRWrite    out  instruction register load enable
//   RegWrite   out  register file write enable
//   ResultSrc  out  00=ALUOut 01=MDR 10=ALUResult 11=Imm
//   ALUSrcA    out  00=PC 01=OldPC 10=RD1
//   ALUSrcB    out  00=RD2 01=Imm 10=const 4
//   ImmSrc     out  000=I 001=S 010=B 011=J 100=U
//   ALUOp      out  00=add 01=branch/sub 10=R-type 11=I-type
//
// Configuration
//   MC_CTRL_LUI_EN  when defined, adds the LUI state (opcode 0110111).
//                   When undefined, 0110111 is decoded as an illegal opcode.
// -----------------------------------------------------------------------------
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       neg,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [1:0] ALUOp
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
`ifdef MC_CTRL_LUI_EN
  localparam logic [6:0] OP_LUI    = 7'b0110111;
`endif

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JALR, S_JUMP
`ifdef MC_CTRL_LUI_EN
    , S_LUI
`endif
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_branch_taken;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: w_state_next = S_MEMADR;
          OP_RTYPE:          w_state_next = S_EXECR;
          OP_ITYPE:          w_state_next = S_EXECI;
          OP_BRANCH:         w_state_next = S_BRANCH;
          OP_JAL:            w_state_next = S_JUMP;
          OP_JALR:           w_state_next = S_JALR;
`ifdef MC_CTRL_LUI_EN
          OP_LUI:            w_state_next = S_LUI;
`endif
          default:           w_state_next = S_FETCH;  // illegal: no writes
        endcase
      end
      S_MEMADR:   w_state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_state_next = S_MEMWB;
      S_EXECR:    w_state_next = S_ALUWB;
      S_EXECI:    w_state_next = S_ALUWB;
      S_JALR:     w_state_next = S_JUMP;
      S_JUMP:     w_state_next = S_ALUWB;  // writes OldPC+4 to rd
      default:    w_state_next = S_FETCH;  // MEMWB, MEMWRITE, ALUWB, BRANCH, LUI
    endcase
  end

  // Branch condition from func3; unsupported func3 values never branch.
  always_comb begin
    case (func3)
      3'b000:  w_branch_taken = zero;
      3'b001:  w_branch_taken = ~zero;
      3'b100:  w_branch_taken = neg;
      3'b101:  w_branch_taken = ~neg;
      default: w_branch_taken = 1'b0;
    endcase
  end

  // Output logic
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ImmSrc    = 3'b000;
    ALUOp     = 2'b00;
    case (r_state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      S_DECODE: begin
        // Precompute the branch/jump target, so the immediate format
        // must already match the instruction type.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        if (opcode == OP_BRANCH)   ImmSrc = 3'b010;
        else if (opcode == OP_JAL) ImmSrc = 3'b011;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (opcode == OP_STORE) ImmSrc = 3'b001;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b11;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCWrite = w_branch_taken;
      end
      S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_JUMP: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
`ifdef MC_CTRL_LUI_EN
      S_LUI: begin
        ImmSrc    = 3'b100;
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//   Scoreboard bench: for each instruction, the expected per-cycle control
//   vectors are pushed to a queue when the opcode is driven, then popped and
//   compared one per cycle on the falling edge. Also checks asynchronous reset
//   mid-instruction and write-enable exclusivity every cycle.
//   Build with +define+MC_CTRL_LUI_EN to exercise the LUI option.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       zero;
  logic       neg;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;

  logic [15:0] exp_q[$];
  string       tag_q[$];
  logic [15:0] w_dut;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .zero(zero), .neg(neg),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUOp(ALUOp)
  );

  always #5 clk = ~clk;

  assign w_dut = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Pack an expected control vector in the same field order as w_dut.
  function automatic logic [15:0] ov(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] imm, input logic [1:0] op);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, op};
  endfunction

  function automatic logic [15:0] e_fetch();       return ov(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00); endfunction
  function automatic logic [15:0] e_decode(input logic [2:0] imm); return ov(0,0,0,0,0,2'b00,2'b01,2'b01,imm,2'b00); endfunction
  function automatic logic [15:0] e_memadr(input logic [2:0] imm); return ov(0,0,0,0,0,2'b00,2'b10,2'b01,imm,2'b00); endfunction
  function automatic logic [15:0] e_memread();     return ov(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00); endfunction
  function automatic logic [15:0] e_memwb();       return ov(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,2'b00); endfunction
  function automatic logic [15:0] e_memwrite();    return ov(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00); endfunction
  function automatic logic [15:0] e_execr();       return ov(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,2'b10); endfunction
  function automatic logic [15:0] e_execi();       return ov(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b11); endfunction
  function automatic logic [15:0] e_aluwb();       return ov(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00); endfunction
  function automatic logic [15:0] e_branch(input logic pcw); return ov(pcw,0,0,0,0,2'b00,2'b10,2'b00,3'b000,2'b01); endfunction
  function automatic logic [15:0] e_jalr();        return ov(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00); endfunction
  function automatic logic [15:0] e_jump();        return ov(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,2'b00); endfunction
  function automatic logic [15:0] e_lui();         return ov(0,0,0,0,1,2'b11,2'b00,2'b00,3'b100,2'b00); endfunction

  task automatic push(input string tag, input logic [15:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  // Drive instruction fields, then pop one expected vector per cycle.
  // Entered and left at a falling edge.
  task automatic drain(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic n);
    logic [15:0] e;
    string       t;
    opcode = op; func3 = f3; zero = z; neg = n;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, w_dut, e);
      @(negedge clk);
      #1;
    end
  endtask

  // Branch helper: FETCH, DECODE(B), BRANCH
  task automatic do_branch(input string name, input logic [2:0] f3, input logic z,
                           input logic n, input logic taken);
    push({name, " fetch"},  e_fetch());
    push({name, " decode"}, e_decode(3'b010));
    push({name, " branch"}, e_branch(taken));
    drain(7'b1100011, f3, z, n);
  endtask

  // Write enables must be mutually exclusive except PCWrite+IRWrite in FETCH.
  always @(negedge clk) begin
    if (!rst && !done)
      check("wr_excl", {15'd0, ((32'(MemWrite) + 32'(RegWrite) + 32'(PCWrite)) > 1)}, 16'd0);
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; opcode = 7'd0; func3 = 3'd0; zero = 1'b0; neg = 1'b0;
    repeat (2) @(negedge clk);
    check("reset state", w_dut, e_fetch());
    rst = 1'b0;

    // lw: 5 cycles, RegWrite only in cycle 5 with ResultSrc=01
    push("lw fetch", e_fetch()); push("lw decode", e_decode(3'b000));
    push("lw memadr", e_memadr(3'b000)); push("lw memread", e_memread());
    push("lw memwb", e_memwb());
    drain(7'b0000011, 3'b010, 1'b0, 1'b0);

    // sw: 4 cycles, S immediate in MEMADR
    push("sw fetch", e_fetch()); push("sw decode", e_decode(3'b000));
    push("sw memadr", e_memadr(3'b001)); push("sw memwrite", e_memwrite());
    drain(7'b0100011, 3'b010, 1'b0, 1'b0);

    // R-type
    push("r fetch", e_fetch()); push("r decode", e_decode(3'b000));
    push("r execr", e_execr()); push("r aluwb", e_aluwb());
    drain(7'b0110011, 3'b000, 1'b0, 1'b0);

    // I-type
    push("i fetch", e_fetch()); push("i decode", e_decode(3'b000));
    push("i execi", e_execi()); push("i aluwb", e_aluwb());
    drain(7'b0010011, 3'b000, 1'b0, 1'b0);

    // Branches across func3 and flag values
    do_branch("beq z1",  3'b000, 1'b1, 1'b0, 1'b1);
    do_branch("beq z0",  3'b000, 1'b0, 1'b0, 1'b0);
    do_branch("bne z0",  3'b001, 1'b0, 1'b0, 1'b1);
    do_branch("bne z1",  3'b001, 1'b1, 1'b0, 1'b0);
    do_branch("blt n1",  3'b100, 1'b0, 1'b1, 1'b1);
    do_branch("blt n0",  3'b100, 1'b0, 1'b0, 1'b0);
    do_branch("bge n1",  3'b101, 1'b0, 1'b1, 1'b0);
    do_branch("bge n0",  3'b101, 1'b1, 1'b0, 1'b1);
    do_branch("bf3 010", 3'b010, 1'b1, 1'b1, 1'b0);

    // jal: 4 cycles, J immediate in DECODE
    push("jal fetch", e_fetch()); push("jal decode", e_decode(3'b011));
    push("jal jump", e_jump()); push("jal aluwb", e_aluwb());
    drain(7'b1101111, 3'b000, 1'b0, 1'b0);

    // jalr: 5 cycles
    push("jalr fetch", e_fetch()); push("jalr decode", e_decode(3'b000));
    push("jalr jalr", e_jalr()); push("jalr jump", e_jump());
    push("jalr aluwb", e_aluwb());
    drain(7'b1100111, 3'b000, 1'b0, 1'b0);

    // lui: option-dependent
    push("lui fetch", e_fetch()); push("lui decode", e_decode(3'b000));
`ifdef MC_CTRL_LUI_EN
    push("lui lui", e_lui());
`endif
    push("lui c3/next fetch", e_fetch());
    drain(7'b0110111, 3'b000, 1'b0, 1'b0);
    // The trailing FETCH above was consumed; realign to an instruction start.
    push("post-lui decode", e_decode(3'b000));
    drain(7'b0000000, 3'b000, 1'b0, 1'b0);

    // Illegal opcode (issued from DECODE above): back to FETCH, no writes
    push("illegal fetch", e_fetch()); push("illegal decode", e_decode(3'b000));
    drain(7'b1111111, 3'b000, 1'b0, 1'b0);
    check("illegal next fetch", w_dut, e_fetch());

    // Asynchronous reset while in MEMREAD
    push("rst lw fetch", e_fetch()); push("rst lw decode", e_decode(3'b000));
    push("rst lw memadr", e_memadr(3'b000));
    drain(7'b0000011, 3'b000, 1'b0, 1'b0);
    check("rst pre memread", w_dut, e_memread());
    #1 rst = 1'b1;
    #1 check("rst async fetch", w_dut, e_fetch());
    @(negedge clk);
    #1 check("rst held fetch", w_dut, e_fetch());
    rst = 1'b0;
    // First edge after release executes FETCH then moves to DECODE.
    push("post-rst fetch", e_fetch()); push("post-rst decode", e_decode(3'b000));
    push("post-rst memadr", e_memadr(3'b000)); push("post-rst memread", e_memread());
    push("post-rst memwb", e_memwb()); push("post-rst next fetch", e_fetch());
    drain(7'b0000011, 3'b000, 1'b0, 1'b0);

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Unused helper guard: e_lui is only pushed in the LUI build.
  logic [15:0] lui_vec_unused;
  assign lui_vec_unused = e_lui();

endmodule
